// File: rtl/serial_queue_pkg.sv
// Shared types and default sizing for the serial front-end of the byte queue.
package serial_queue_pkg;

    localparam int DEF_WORD_W        = 8;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_GLITCH_CYCLES = 4;

    typedef enum logic [1:0] {
        START = 2'd0,
        RECV  = 2'd1,
        HOLD  = 2'd2,
        ENQ   = 2'd3
    } state_t;

endpackage

// File: rtl/serial_queue_ctrl_strobe_filter.sv
// Synchronizer, glitch counter and one-shot for one slow strobe input.
// Emits a single-cycle event once the strobe has been high GLITCH_CYCLES synchronized cycles.
module strobe_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int GLITCH_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_strobe,
    output logic o_event
);

    localparam int CNT_W = $clog2(GLITCH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(GLITCH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(GLITCH_CYCLES - 1);

    logic             r_sync [SYNC_STAGES];
    logic [CNT_W-1:0] r_cnt;
    logic             r_armed;
    logic             r_event;
    logic             w_sync;

    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        if (gi == 0) begin : g_first
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_sync[0] <= 1'b0;
                else        r_sync[0] <= i_strobe;
            end
        end else begin : g_next
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_sync[gi] <= 1'b0;
                else        r_sync[gi] <= r_sync[gi-1];
            end
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Armed only by a synchronized low, so a strobe held across reset or a
    // long high period never yields more than one event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_armed <= 1'b0;
            r_event <= 1'b0;
        end else begin
            r_event <= 1'b0;
            if (!w_sync) begin
                r_cnt   <= '0;
                r_armed <= 1'b1;
            end else begin
                if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
                if (r_armed && r_cnt == CNT_ARM) begin
                    r_event <= 1'b1;
                    r_armed <= 1'b0;
                end
            end
        end
    end

    assign o_event = r_event;

endmodule

// File: rtl/serial_queue_ctrl.sv
// Serial-bit assembler and enqueue/dequeue sequencer in front of the byte queue.
// Strobes are filtered into events; the FSM builds words LSB-first and issues one-cycle commands.
module serial_queue_ctrl
    import serial_queue_pkg::*;
#(
    parameter int WORD_W        = DEF_WORD_W,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int GLITCH_CYCLES = DEF_GLITCH_CYCLES
) (
    input  logic              clock_1MHz,
    input  logic              rst,
    input  logic              data_in,
    input  logic              write_in,
    input  logic              enqueue_in,
    input  logic              dequeue_in,
    input  logic              q_full,
    input  logic              q_empty,
    input  logic [WORD_W-1:0] q_deq_data,
    output logic              q_enq,
    output logic [WORD_W-1:0] q_enq_data,
    output logic              q_deq,
    output logic              status_out,
    output logic [WORD_W-1:0] data_out,
    output logic              err_out
);

    localparam int BC_W = $clog2(WORD_W);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(WORD_W - 1);

    state_t            r_state;
    logic [WORD_W-1:0] r_shreg;
    logic [BC_W-1:0]   r_bitcnt;
    logic              r_q_enq;
    logic [WORD_W-1:0] r_q_enq_data;
    logic              r_q_deq;
    logic              r_deq_d;
    logic              r_status;
    logic [WORD_W-1:0] r_data_out;
    logic              r_err;
    logic              r_dsync [SYNC_STAGES];

    logic [2:0] w_strobe;
    logic [2:0] w_evt;
    logic       w_wr_evt;
    logic       w_enq_evt;
    logic       w_deq_evt;
    logic       w_bit;
    logic       w_enq_acc;
    logic       w_enq_rej;
    logic       w_deq_acc;
    logic       w_deq_rej;

    assign w_strobe = {dequeue_in, enqueue_in, write_in};

    for (genvar gi = 0; gi < 3; gi++) begin : g_filt
        strobe_filter #(
            .SYNC_STAGES   (SYNC_STAGES),
            .GLITCH_CYCLES (GLITCH_CYCLES)
        ) u_filt (
            .clk      (clock_1MHz),
            .rst_n    (rst),
            .i_strobe (w_strobe[gi]),
            .o_event  (w_evt[gi])
        );
    end

    assign w_wr_evt  = w_evt[0];
    assign w_enq_evt = w_evt[1];
    assign w_deq_evt = w_evt[2];

    // data_in gets the same synchronizer depth so it lines up with the write event.
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_dsync
        if (gi == 0) begin : g_first
            always_ff @(posedge clock_1MHz or negedge rst) begin
                if (!rst) r_dsync[0] <= 1'b0;
                else      r_dsync[0] <= data_in;
            end
        end else begin : g_next
            always_ff @(posedge clock_1MHz or negedge rst) begin
                if (!rst) r_dsync[gi] <= 1'b0;
                else      r_dsync[gi] <= r_dsync[gi-1];
            end
        end
    end

    assign w_bit = r_dsync[SYNC_STAGES-1];

    assign w_enq_acc = w_enq_evt && (r_state == HOLD) && !q_full;
    assign w_enq_rej = w_enq_evt && ((r_state == RECV) || ((r_state == HOLD) && q_full));
    assign w_deq_acc = w_deq_evt && (r_state != START) && !q_empty;
    assign w_deq_rej = w_deq_evt && (r_state != START) && q_empty;

    always_ff @(posedge clock_1MHz or negedge rst) begin
        if (!rst) begin
            r_state      <= START;
            r_shreg      <= '0;
            r_bitcnt     <= '0;
            r_q_enq      <= 1'b0;
            r_q_enq_data <= '0;
            r_q_deq      <= 1'b0;
            r_deq_d      <= 1'b0;
            r_status     <= 1'b0;
            r_data_out   <= '0;
            r_err        <= 1'b0;
        end else begin
            r_q_enq <= 1'b0;
            r_q_deq <= w_deq_acc;
            r_deq_d <= r_q_deq;
            // Queue read is registered: head is valid the cycle after the pop.
            if (r_deq_d) r_data_out <= q_deq_data;

            if (w_enq_rej || w_deq_rej)      r_err <= 1'b1;
            else if (w_enq_acc || w_deq_acc) r_err <= 1'b0;

            case (r_state)
                START: begin
                    r_state  <= RECV;
                    r_status <= 1'b1;
                end
                RECV: begin
                    if (w_wr_evt) begin
                        r_shreg <= {w_bit, r_shreg[WORD_W-1:1]};
                        if (r_bitcnt == BC_LAST) begin
                            r_bitcnt <= '0;
                            r_state  <= HOLD;
                            r_status <= 1'b0;
                        end else begin
                            r_bitcnt <= r_bitcnt + BC_W'(1);
                        end
                    end
                end
                HOLD: begin
                    // A rejected push keeps the word here for a later retry.
                    if (w_enq_acc) begin
                        r_state      <= ENQ;
                        r_q_enq      <= 1'b1;
                        r_q_enq_data <= r_shreg;
                    end
                end
                ENQ: begin
                    r_state  <= RECV;
                    r_status <= 1'b1;
                end
                default: begin
                    r_state  <= START;
                    r_status <= 1'b0;
                end
            endcase
        end
    end

    assign q_enq      = r_q_enq;
    assign q_enq_data = r_q_enq_data;
    assign q_deq      = r_q_deq;
    assign status_out = r_status;
    assign data_out   = r_data_out;
    assign err_out    = r_err;

endmodule

// File: tb/tb_serial_queue_ctrl.sv
// Bench for serial_queue_ctrl: directed vector table, timing sequences and random ops
// checked against a word-level model, with a small queue model answering the DUT.
`timescale 1ns/1ps
module tb_serial_queue_ctrl;

    localparam int WORD_W = 8;
    localparam int SYNC   = 2;
    localparam int GLITCH = 4;
    localparam int CAP    = 2;
    localparam int GAP    = 8;
    localparam int K_WR   = 0;
    localparam int K_EN   = 1;
    localparam int K_DQ   = 2;

    logic              clock_1MHz;
    logic              rst;
    logic              data_in, write_in, enqueue_in, dequeue_in;
    logic              q_full, q_empty;
    logic [WORD_W-1:0] q_deq_data;
    logic              q_enq, q_deq, status_out, err_out;
    logic [WORD_W-1:0] q_enq_data, data_out;

    serial_queue_ctrl #(
        .WORD_W        (WORD_W),
        .SYNC_STAGES   (SYNC),
        .GLITCH_CYCLES (GLITCH)
    ) dut (
        .clock_1MHz (clock_1MHz),
        .rst        (rst),
        .data_in    (data_in),
        .write_in   (write_in),
        .enqueue_in (enqueue_in),
        .dequeue_in (dequeue_in),
        .q_full     (q_full),
        .q_empty    (q_empty),
        .q_deq_data (q_deq_data),
        .q_enq      (q_enq),
        .q_enq_data (q_enq_data),
        .q_deq      (q_deq),
        .status_out (status_out),
        .data_out   (data_out),
        .err_out    (err_out)
    );

    initial clock_1MHz = 1'b0;
    always #500 clock_1MHz = ~clock_1MHz;

    int n_cmp = 0;
    int n_bad = 0;

    // Queue environment: watches the DUT commands mid-cycle.
    logic [WORD_W-1:0] env_q [$];
    int                env_size = 0;
    logic [WORD_W-1:0] env_data = '0;
    int                enq_cnt = 0, deq_cnt = 0, long_pulse = 0;
    logic [WORD_W-1:0] last_enq_data = '0;
    bit                prev_enq = 0, prev_deq = 0;
    bit                force_full = 0;

    assign q_full     = force_full || (env_size >= CAP);
    assign q_empty    = (env_size == 0);
    assign q_deq_data = env_data;

    always @(negedge clock_1MHz) begin
        if (q_enq) begin
            enq_cnt++;
            last_enq_data = q_enq_data;
            if (prev_enq) long_pulse++;
            if (env_q.size() < CAP) env_q.push_back(q_enq_data);
        end
        if (q_deq) begin
            deq_cnt++;
            if (prev_deq) long_pulse++;
            if (env_q.size() > 0) env_data = env_q.pop_front();
        end
        prev_enq = q_enq;
        prev_deq = q_deq;
        env_size = env_q.size();
    end

    // Reference model: bit count, partial word, error flag, output word and queue contents.
    int                mcnt = 0;
    logic [WORD_W-1:0] mword = '0;
    bit                merr = 0;
    logic [WORD_W-1:0] mdout = '0;
    logic [WORD_W-1:0] mq [$];
    int                exp_enq, exp_deq;
    logic [WORD_W-1:0] exp_word;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock_1MHz);
        #1;
    endtask

    task automatic drive(input int kind, input logic v);
        case (kind)
            K_WR:    write_in   = v;
            K_EN:    enqueue_in = v;
            default: dequeue_in = v;
        endcase
    endtask

    task automatic model_apply(input int kind, input bit b);
        exp_enq = 0;
        exp_deq = 0;
        if (kind == K_WR) begin
            if (mcnt < WORD_W) begin
                mword[mcnt] = b;
                mcnt++;
            end
        end else if (kind == K_EN) begin
            if (mcnt < WORD_W || force_full || mq.size() >= CAP) begin
                merr = 1;
            end else begin
                mq.push_back(mword);
                exp_enq  = 1;
                exp_word = mword;
                mword    = '0;
                mcnt     = 0;
                merr     = 0;
            end
        end else begin
            if (mq.size() == 0) begin
                merr = 1;
            end else begin
                mdout   = mq.pop_front();
                exp_deq = 1;
                merr    = 0;
            end
        end
    endtask

    task automatic check_model(input int e0, input int d0);
        chk("status", int'(status_out), int'(mcnt < WORD_W));
        chk("err", int'(err_out), int'(merr));
        chk("enq_pulses", enq_cnt - e0, exp_enq);
        if (exp_enq != 0) chk("enq_data", int'(last_enq_data), int'(exp_word));
        chk("deq_pulses", deq_cnt - d0, exp_deq);
        chk("data_out", int'(data_out), int'(mdout));
    endtask

    task automatic do_op(input int kind, input bit b, input int hi);
        int e0, d0;
        e0 = enq_cnt;
        d0 = deq_cnt;
        data_in = b;
        drive(kind, 1'b1);
        cyc(hi);
        drive(kind, 1'b0);
        cyc(GAP);
        exp_enq = 0;
        exp_deq = 0;
        if (hi >= GLITCH) model_apply(kind, b);
        check_model(e0, d0);
        $display("op kind=%0d bit=%0d hi=%0d ff=%0d -> status=%0d err=%0d enq=%0d deq=%0d data_out=%02h",
                 kind, b, hi, force_full, status_out, err_out, enq_cnt - e0, deq_cnt - d0, data_out);
    endtask

    typedef struct {
        int                kind;
        bit                b;
        int                hi;
        bit                ff;
        bit                exp_status;
        bit                exp_err;
        bit                exp_enq;
        logic [WORD_W-1:0] exp_data;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    initial begin
        int k;
        int e0, d0;
        bit b;

        // Glitch, then 0x99 LSB-first (one bit strobed for exactly GLITCH cycles).
        tbl[0]  = '{K_WR, 1'b1,  3, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{K_WR, 1'b1, 10, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[2]  = '{K_WR, 1'b0,  4, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[3]  = '{K_WR, 1'b0, 10, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[4]  = '{K_WR, 1'b1, 10, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[5]  = '{K_WR, 1'b1, 10, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[6]  = '{K_WR, 1'b0, 10, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[7]  = '{K_WR, 1'b0, 10, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[8]  = '{K_WR, 1'b1, 10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[9]  = '{K_EN, 1'b0, 10, 1'b0, 1'b1, 1'b0, 1'b1, 8'h99};
        tbl[10] = '{K_DQ, 1'b0, 10, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[11] = '{K_DQ, 1'b0, 10, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        // Three bits, a rejected enqueue in RECV, then five more: 0xD3.
        tbl[12] = '{K_WR, 1'b1, 10, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[13] = '{K_WR, 1'b1, 10, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[14] = '{K_WR, 1'b0, 10, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[15] = '{K_EN, 1'b0, 10, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[16] = '{K_WR, 1'b0, 10, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[17] = '{K_WR, 1'b1, 10, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[18] = '{K_WR, 1'b0, 10, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[19] = '{K_WR, 1'b1, 10, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[20] = '{K_WR, 1'b1, 10, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[21] = '{K_EN, 1'b0, 10, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[22] = '{K_EN, 1'b0, 10, 1'b0, 1'b1, 1'b0, 1'b1, 8'hD3};

        rst = 1'b0;
        data_in = 0; write_in = 0; enqueue_in = 0; dequeue_in = 0;
        cyc(3);
        chk("reset_status", int'(status_out), 0);
        chk("reset_err", int'(err_out), 0);
        chk("reset_q_enq", int'(q_enq), 0);
        chk("reset_q_deq", int'(q_deq), 0);
        chk("reset_data_out", int'(data_out), 0);
        rst = 1'b1;
        #1;
        chk("start_status", int'(status_out), 0);
        cyc(1);
        chk("recv_status", int'(status_out), 1);
        $display("reset released, status_out=%0d", status_out);

        for (int i = 0; i < NV; i++) begin
            force_full = tbl[i].ff;
            do_op(tbl[i].kind, tbl[i].b, tbl[i].hi);
            chk("tbl_status", int'(status_out), int'(tbl[i].exp_status));
            chk("tbl_err", int'(err_out), int'(tbl[i].exp_err));
            if (tbl[i].exp_enq) chk("tbl_enq_data", int'(last_enq_data), int'(tbl[i].exp_data));
        end
        force_full = 0;

        // Long dequeue strobe: one pop only, data_out takes the queued 0xD3.
        do_op(K_DQ, 1'b0, 100);
        chk("long_deq_data", int'(data_out), 8'hD3);

        // Event latency: status_out falls SYNC+GLITCH+1 edges after the 8th write starts.
        for (int i = 0; i < 7; i++) do_op(K_WR, 1'($urandom_range(0, 1)), 6);
        b = 1'($urandom_range(0, 1));
        data_in  = b;
        write_in = 1'b1;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc(1);
            if (!status_out) begin
                k = i;
                break;
            end
        end
        chk("write_latency_edges", k, SYNC + GLITCH + 1);
        write_in = 1'b0;
        cyc(GAP);
        model_apply(K_WR, b);
        $display("latency edges=%0d", k);
        do_op(K_EN, 1'b0, 8);

        // Reset mid-byte; the next word must carry no residue.
        for (int i = 0; i < 5; i++) do_op(K_WR, 1'b1, 8);
        rst = 1'b0;
        #1;
        chk("midrst_status", int'(status_out), 0);
        chk("midrst_err", int'(err_out), 0);
        chk("midrst_data_out", int'(data_out), 0);
        chk("midrst_q_enq_data", int'(q_enq_data), 0);
        mcnt = 0; mword = '0; merr = 0; mdout = '0;
        cyc(2);
        rst = 1'b1;
        cyc(2);
        $display("mid-byte reset applied and released");
        for (int i = 0; i < WORD_W; i++) do_op(K_WR, (8'hA5 >> i) & 1, 8);
        do_op(K_EN, 1'b0, 8);
        chk("a5_enq_data", int'(last_enq_data), 8'hA5);

        // Random operations against the model.
        for (int i = 0; i < 60; i++) begin
            int r, hi;
            r  = $urandom_range(0, 5);
            hi = ($urandom_range(0, 4) == 0) ? $urandom_range(1, GLITCH - 1) : $urandom_range(GLITCH, 12);
            force_full = ($urandom_range(0, 9) == 0);
            e0 = enq_cnt; d0 = deq_cnt;
            do_op((r <= 3) ? K_WR : ((r == 4) ? K_EN : K_DQ), 1'($urandom_range(0, 1)), hi);
        end
        force_full = 0;

        chk("single_cycle_pulses", long_pulse, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
